// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_pkg
// Description : Shared constants, register-select enum and offset decoder
//               for the processor-to-Memory/MMIO bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0000_0200;

    localparam logic [4:0] IN0_OFS  = 5'h00;
    localparam logic [4:0] IN1_OFS  = 5'h04;
    localparam logic [4:0] IN2_OFS  = 5'h08;
    localparam logic [4:0] OUT0_OFS = 5'h10;
    localparam logic [4:0] OUT1_OFS = 5'h14;
    localparam logic [4:0] OUT2_OFS = 5'h18;
    localparam logic [4:0] CNT_OFS  = 5'h1C;

    typedef enum logic [2:0] {
        REG_NONE = 3'd0,
        REG_IN0  = 3'd1,
        REG_IN1  = 3'd2,
        REG_IN2  = 3'd3,
        REG_OUT0 = 3'd4,
        REG_OUT1 = 3'd5,
        REG_OUT2 = 3'd6,
        REG_CNT  = 3'd7
    } mmio_reg_t;

    // Takes a word offset from the MMIO base; anything past the 32-byte
    // window or on the hole at 0x0C selects nothing.
    function automatic mmio_reg_t decode_ofs(input logic [29:0] i_word_ofs);
        mmio_reg_t v_sel;
        v_sel = REG_NONE;
        if (i_word_ofs[29:3] == '0) begin
            case ({i_word_ofs[2:0], 2'b00})
                IN0_OFS:  v_sel = REG_IN0;
                IN1_OFS:  v_sel = REG_IN1;
                IN2_OFS:  v_sel = REG_IN2;
                OUT0_OFS: v_sel = REG_OUT0;
                OUT1_OFS: v_sel = REG_OUT1;
                OUT2_OFS: v_sel = REG_OUT2;
                CNT_OFS:  v_sel = REG_CNT;
                default:  v_sel = REG_NONE;
            endcase
        end
        return v_sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_sync2.sv
`default_nettype none
// ============================================================================
// Module      : mmio_sync2
// Description : Parameterized-width two-flop synchronizer, synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_sync2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule
`default_nettype wire

// File: rtl/mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mmio_bridge
// Description : Routes processor data requests to Memory below MMIO_BASE and
//               to a small bank of I/O registers and a cycle counter above it.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        proc_val,
    output logic        proc_wait,
    input  logic        proc_type,
    input  logic [31:0] proc_addr,
    input  logic [31:0] proc_wdata,
    output logic [31:0] proc_rdata,
    output logic        mem_val,
    output logic        mem_type,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_wait,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic [31:0] out0,
    output logic [31:0] out1,
    output logic [31:0] out2,
    output logic [2:0]  out_strobe
);

    logic        w_is_mem;
    logic        w_is_io;
    logic        w_io_wr;
    logic [29:0] w_word_ofs;
    mmio_reg_t   w_sel;
    logic [31:0] w_in0_sync;
    logic [31:0] w_in1_sync;
    logic [31:0] w_in2_sync;
    logic [31:0] w_io_rdata;

    logic [31:0] r_out0;
    logic [31:0] r_out1;
    logic [31:0] r_out2;
    logic [2:0]  r_strobe;
    logic [31:0] r_cnt;

    // Decode works on word addresses so the byte-lane bits never matter.
    assign w_is_mem   = proc_addr[31:2] < MMIO_BASE[31:2];
    assign w_is_io    = !w_is_mem;
    assign w_word_ofs = proc_addr[31:2] - MMIO_BASE[31:2];
    assign w_sel      = decode_ofs(w_word_ofs);
    assign w_io_wr    = proc_val && proc_type && w_is_io && !rst;

    assign mem_val   = proc_val && w_is_mem && !rst;
    assign mem_type  = proc_type;
    assign mem_addr  = proc_addr;
    assign mem_wdata = proc_wdata;
    assign proc_wait = w_is_mem ? mem_wait : 1'b0;

    mmio_sync2 #(.WIDTH(32)) u_sync_in0 (.clk(clk), .rst(rst), .i_d(in0), .o_q(w_in0_sync));
    mmio_sync2 #(.WIDTH(32)) u_sync_in1 (.clk(clk), .rst(rst), .i_d(in1), .o_q(w_in1_sync));
    mmio_sync2 #(.WIDTH(32)) u_sync_in2 (.clk(clk), .rst(rst), .i_d(in2), .o_q(w_in2_sync));

    // A counter load replaces the increment on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out0   <= '0;
            r_out1   <= '0;
            r_out2   <= '0;
            r_strobe <= '0;
            r_cnt    <= '0;
        end else begin
            r_strobe <= '0;
            r_cnt    <= r_cnt + 32'd1;
            if (w_io_wr) begin
                case (w_sel)
                    REG_OUT0: begin
                        r_out0      <= proc_wdata;
                        r_strobe[0] <= 1'b1;
                    end
                    REG_OUT1: begin
                        r_out1      <= proc_wdata;
                        r_strobe[1] <= 1'b1;
                    end
                    REG_OUT2: begin
                        r_out2      <= proc_wdata;
                        r_strobe[2] <= 1'b1;
                    end
                    REG_CNT:  r_cnt <= proc_wdata;
                    default:  ;
                endcase
            end
        end
    end

    always_comb begin
        w_io_rdata = '0;
        case (w_sel)
            REG_IN0:  w_io_rdata = w_in0_sync;
            REG_IN1:  w_io_rdata = w_in1_sync;
            REG_IN2:  w_io_rdata = w_in2_sync;
            REG_OUT0: w_io_rdata = r_out0;
            REG_OUT1: w_io_rdata = r_out1;
            REG_OUT2: w_io_rdata = r_out2;
            REG_CNT:  w_io_rdata = r_cnt;
            default:  w_io_rdata = '0;
        endcase
    end

    assign proc_rdata = (!proc_val || proc_type || rst) ? 32'h0 :
                        (w_is_mem ? mem_rdata : w_io_rdata);

    assign out0       = r_out0;
    assign out1       = r_out1;
    assign out2       = r_out2;
    assign out_strobe = r_strobe;

endmodule
`default_nettype wire

// File: tb/tb_mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_bridge
// Description : Self-checking bench for mmio_bridge with a Memory model and a
//               behavioural model of the MMIO register bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        proc_val;
    logic        proc_wait;
    logic        proc_type;
    logic [31:0] proc_addr;
    logic [31:0] proc_wdata;
    logic [31:0] proc_rdata;
    logic        mem_val;
    logic        mem_type;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wait;
    logic [31:0] mem_rdata;
    logic [31:0] in0, in1, in2;
    logic [31:0] out0, out1, out2;
    logic [2:0]  out_strobe;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmio_bridge #(.MMIO_BASE(32'h200)) dut (
        .clk(clk), .rst(rst),
        .proc_val(proc_val), .proc_wait(proc_wait), .proc_type(proc_type),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(proc_rdata),
        .mem_val(mem_val), .mem_type(mem_type), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wait(mem_wait), .mem_rdata(mem_rdata),
        .in0(in0), .in1(in1), .in2(in2),
        .out0(out0), .out1(out1), .out2(out2), .out_strobe(out_strobe)
    );

    // 512-byte word-addressed Memory, combinational read
    logic [31:0] mem    [128];
    logic [31:0] shadow [128];
    assign mem_rdata = mem[mem_addr[8:2]];
    always @(posedge clk) begin
        if (mem_val && mem_type && !mem_wait) mem[mem_addr[8:2]] <= mem_wdata;
    end

    // Reference state of the MMIO bank
    logic [31:0] m_out [3];
    logic [2:0]  m_strobe;
    logic [31:0] m_cnt;
    logic [31:0] m_s1  [3];
    logic [31:0] m_s2  [3];

    task automatic cycle();
        logic [31:0] ins [3];
        logic [31:0] a;
        logic        r, wr;
        logic [31:0] wd;
        ins[0] = in0; ins[1] = in1; ins[2] = in2;
        a  = proc_addr & 32'hFFFF_FFFC;
        r  = rst;
        wr = proc_val && proc_type;
        wd = proc_wdata;
        if (!r && wr && a < 32'h200 && !mem_wait) shadow[a[8:2]] = wd;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 3; i++) begin m_out[i] = 0; m_s1[i] = 0; m_s2[i] = 0; end
            m_strobe = 0;
            m_cnt    = 0;
        end else begin
            m_strobe = 0;
            m_cnt    = m_cnt + 1;
            for (int i = 0; i < 3; i++) begin m_s2[i] = m_s1[i]; m_s1[i] = ins[i]; end
            if (wr && a >= 32'h200) begin
                case (a - 32'h200)
                    32'h10: begin m_out[0] = wd; m_strobe[0] = 1'b1; end
                    32'h14: begin m_out[1] = wd; m_strobe[1] = 1'b1; end
                    32'h18: begin m_out[2] = wd; m_strobe[2] = 1'b1; end
                    32'h1C: m_cnt = wd;
                    default: ;
                endcase
            end
        end
        #1;
    endtask

    function automatic logic [31:0] exp_rdata();
        logic [31:0] a;
        a = proc_addr & 32'hFFFF_FFFC;
        if (rst || !proc_val || proc_type) return 32'h0;
        if (a < 32'h200) return shadow[a[8:2]];
        case (a - 32'h200)
            32'h00:  return m_s2[0];
            32'h04:  return m_s2[1];
            32'h08:  return m_s2[2];
            32'h10:  return m_out[0];
            32'h14:  return m_out[1];
            32'h18:  return m_out[2];
            32'h1C:  return m_cnt;
            default: return 32'h0;
        endcase
    endfunction

    task automatic drive(input logic v, input logic t, input logic [31:0] a, input logic [31:0] d);
        proc_val = v; proc_type = t; proc_addr = a; proc_wdata = d;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h21C, 32'h0);
        checks++; if (proc_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp %h", proc_rdata, 32'h0); end
        cycle();
        cycle();
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'h21C, 32'h0);
        checks++; if ({out0, out1, out2} !== 96'h0) begin errors++; $display("FAIL rst_outs got %h %h %h exp 0", out0, out1, out2); end
        checks++; if (out_strobe !== 3'b000) begin errors++; $display("FAIL rst_strobe got %b exp 000", out_strobe); end
        checks++; if (proc_rdata !== 32'h0) begin errors++; $display("FAIL rst_cnt0 got %h exp %h", proc_rdata, 32'h0); end
        cycle();
        checks++; if (proc_rdata !== 32'h1) begin errors++; $display("FAIL rst_cnt1 got %h exp %h", proc_rdata, 32'h1); end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (proc_rdata !== 32'h0) begin errors++; $display("FAIL idle_rdata got %h exp %h", proc_rdata, 32'h0); end
        cycle();
    endtask

    task automatic test_passthrough();
        mem_wait = 1'b0;
        drive(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
        checks++; if ({mem_val, mem_type, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL pt_wr_req got %b %b %h %h exp 1 1 00000100 deadbeef", mem_val, mem_type, mem_addr, mem_wdata); end
        checks++; if (proc_rdata !== 32'h0) begin errors++; $display("FAIL pt_wr_rdata got %h exp 0", proc_rdata); end
        cycle();
        drive(1'b1, 1'b0, 32'h100, 32'h0);
        checks++; if ({mem_val, mem_addr} !== {1'b1, 32'h100}) begin errors++; $display("FAIL pt_rd_req got %b %h exp 1 00000100", mem_val, mem_addr); end
        checks++; if (proc_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pt_rd_data got %h exp deadbeef", proc_rdata); end
        mem_wait = 1'b1; #1;
        checks++; if (proc_wait !== 1'b1) begin errors++; $display("FAIL pt_wait got %b exp 1", proc_wait); end
        drive(1'b1, 1'b0, 32'h210, 32'h0);
        checks++; if (proc_wait !== 1'b0) begin errors++; $display("FAIL io_nowait got %b exp 0", proc_wait); end
        mem_wait = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
    endtask

    task automatic test_out_write();
        drive(1'b1, 1'b1, 32'h210, 32'h4);
        checks++; if (mem_val !== 1'b0) begin errors++; $display("FAIL ow_memval_t got %b exp 0", mem_val); end
        cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (out0 !== 32'h4 || out_strobe !== 3'b001) begin errors++; $display("FAIL ow_t1 got %h %b exp 00000004 001", out0, out_strobe); end
        checks++; if (mem_val !== 1'b0) begin errors++; $display("FAIL ow_memval_t1 got %b exp 0", mem_val); end
        cycle();
        checks++; if (out0 !== 32'h4 || out_strobe !== 3'b000) begin errors++; $display("FAIL ow_t2 got %h %b exp 00000004 000", out0, out_strobe); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 32'h214, 32'hA1A1_0001);
        cycle();
        drive(1'b1, 1'b1, 32'h214, 32'hB2B2_0002);
        checks++; if (out1 !== 32'hA1A1_0001 || out_strobe !== 3'b010) begin errors++; $display("FAIL b2b_1 got %h %b exp a1a10001 010", out1, out_strobe); end
        cycle();
        drive(1'b1, 1'b1, 32'h218, 32'hC3C3_0003);
        checks++; if (out1 !== 32'hB2B2_0002 || out_strobe !== 3'b010) begin errors++; $display("FAIL b2b_2 got %h %b exp b2b20002 010", out1, out_strobe); end
        cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (out2 !== 32'hC3C3_0003 || out_strobe !== 3'b100) begin errors++; $display("FAIL b2b_3 got %h %b exp c3c30003 100", out2, out_strobe); end
        cycle();
        checks++; if (out_strobe !== 3'b000) begin errors++; $display("FAIL b2b_4 got %b exp 000", out_strobe); end
    endtask

    task automatic test_sync();
        in1 = 32'h0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        cycle(); cycle(); cycle();
        in1 = 32'h55;
        drive(1'b1, 1'b0, 32'h204, 32'h0);
        cycle();
        checks++; if (proc_rdata !== 32'h0) begin errors++; $display("FAIL sync_k got %h exp 0", proc_rdata); end
        cycle();
        checks++; if (proc_rdata !== 32'h55) begin errors++; $display("FAIL sync_k1 got %h exp 00000055", proc_rdata); end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_counter();
        drive(1'b1, 1'b1, 32'h21C, 32'hFFFF_FFFE);
        cycle();
        drive(1'b1, 1'b0, 32'h21C, 32'h0);
        checks++; if (proc_rdata !== 32'hFFFF_FFFE) begin errors++; $display("FAIL cnt_load got %h exp fffffffe", proc_rdata); end
        cycle();
        checks++; if (proc_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cnt_inc got %h exp ffffffff", proc_rdata); end
        cycle();
        checks++; if (proc_rdata !== 32'h0) begin errors++; $display("FAIL cnt_wrap got %h exp 0", proc_rdata); end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_unmapped();
        drive(1'b1, 1'b1, 32'h200, $urandom);
        cycle();
        drive(1'b1, 1'b1, 32'h220, $urandom);
        checks++; if (out0 !== m_out[0] || out1 !== m_out[1] || out2 !== m_out[2] || out_strobe !== 3'b000) begin
            errors++; $display("FAIL unm_200 got %h %h %h %b exp %h %h %h 000", out0, out1, out2, out_strobe, m_out[0], m_out[1], m_out[2]); end
        cycle();
        drive(1'b1, 1'b0, 32'h20C, 32'h0);
        checks++; if (out0 !== m_out[0] || out1 !== m_out[1] || out2 !== m_out[2] || out_strobe !== 3'b000) begin
            errors++; $display("FAIL unm_220 got %h %h %h %b exp %h %h %h 000", out0, out1, out2, out_strobe, m_out[0], m_out[1], m_out[2]); end
        checks++; if (proc_rdata !== 32'h0) begin errors++; $display("FAIL unm_rd20c got %h exp 0", proc_rdata); end
        rst = 1'b1;
        drive(1'b1, 1'b1, 32'h214, 32'h1234_5678);
        cycle();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (out1 !== 32'h0 || out_strobe !== 3'b000) begin errors++; $display("FAIL rst_wr got %h %b exp 0 000", out1, out_strobe); end
        cycle();
        checks++; if (out1 !== 32'h0 || out_strobe !== 3'b000) begin errors++; $display("FAIL rst_wr2 got %h %b exp 0 000", out1, out_strobe); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic        ev;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            in0 = $urandom; in1 = $urandom; in2 = $urandom;
            mem_wait = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 32'h1FF)) : 32'h200 + 32'($urandom_range(0, 32'h3F));
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, $urandom);
            ev = proc_val && (a < 32'h200) && !rst;
            checks++; if (proc_rdata !== exp_rdata()) begin errors++; $display("FAIL rnd_rdata n=%0d addr %h got %h exp %h", n, a, proc_rdata, exp_rdata()); end
            checks++; if (mem_val !== ev || proc_wait !== ((a < 32'h200) ? mem_wait : 1'b0)) begin
                errors++; $display("FAIL rnd_memctl n=%0d got val %b wait %b exp val %b wait %b", n, mem_val, proc_wait, ev, (a < 32'h200) ? mem_wait : 1'b0); end
            checks++; if (mem_addr !== a || mem_wdata !== proc_wdata || mem_type !== proc_type) begin
                errors++; $display("FAIL rnd_memreq n=%0d got %h %h %b exp %h %h %b", n, mem_addr, mem_wdata, mem_type, a, proc_wdata, proc_type); end
            cycle();
            checks++; if (out0 !== m_out[0] || out1 !== m_out[1] || out2 !== m_out[2] || out_strobe !== m_strobe) begin
                errors++; $display("FAIL rnd_regs n=%0d got %h %h %h %b exp %h %h %h %b", n, out0, out1, out2, out_strobe, m_out[0], m_out[1], m_out[2], m_strobe); end
        end
        rst = 1'b0;
        mem_wait = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin mem[i] = 32'h0; shadow[i] = 32'h0; end
        rst = 1'b1; mem_wait = 1'b0;
        in0 = 32'h0; in1 = 32'h0; in2 = 32'h0;
        proc_val = 1'b0; proc_type = 1'b0; proc_addr = 32'h0; proc_wdata = 32'h0;
        m_cnt = 32'h0; m_strobe = 3'b000;
        for (int i = 0; i < 3; i++) begin m_out[i] = 0; m_s1[i] = 0; m_s2[i] = 0; end
        #1;
        test_reset();
        test_passthrough();
        test_out_write();
        test_back_to_back();
        test_sync();
        test_counter();
        test_unmapped();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired after 1ms sim time, exp finish earlier");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mmio_bridge.md
# mmio_bridge

Address-decoding bridge between the processor data port and the data port of the word-addressed Memory block. Requests below `MMIO_BASE` pass through to Memory unchanged; requests at or above it go to a small bank of memory-mapped I/O registers: three synchronized input words, three output registers with write strobes, and a free-running cycle counter. The processor stores to `0x210` to drive `out0`, so the instruction-memory program can talk to board I/O without touching physical memory.

## Interface
Parameters:
- `MMIO_BASE`, default `32'h200`: first MMIO address; equals the full Memory size of 512 B.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `proc_val`  in  1  request valid.
- `proc_wait`  out  1  request stalled.
- `proc_type`  in  1  0 = read, 1 = write.
- `proc_addr`  in  32  byte address.
- `proc_wdata`  in  32  write data.
- `proc_rdata`  out  32  read data.
- `mem_val`, `mem_type`, `mem_addr`, `mem_wdata`  out  1/1/32/32  request to Memory.
- `mem_wait`, `mem_rdata`  in  1/32  response from Memory.
- `in0`, `in1`, `in2`  in  32 each  asynchronous external inputs.
- `out0`, `out1`, `out2`  out  32 each  registered outputs.
- `out_strobe`  out  3  one-cycle pulse per output register, set after a write to it.

## Operation
Decoding:
- `is_mem = proc_addr < MMIO_BASE`.
- `is_io = !is_mem`.
- `addr[1:0]` is ignored everywhere.

Memory path:
- `mem_val = proc_val & is_mem & !rst`.
- `mem_type`, `mem_addr`, `mem_wdata` are direct copies of the `proc_*` signals.
- `proc_wait = is_mem ? mem_wait : 0`.

MMIO map, as offsets from `MMIO_BASE`:
- `0x00`, `0x04`, `0x08`: `in0`–`in2` after synchronization. Read-only; writes are ignored.
- `0x10`, `0x14`, `0x18`: `out0`–`out2`. Read/write.
- `0x1C`: cycle counter. A read returns the current value; a write loads it.
- Any other `is_io` address: reads return `0`; writes are ignored, with no strobe.

Read data:
- `proc_rdata = mem_rdata` for memory reads.
- `proc_rdata` = MMIO register value for MMIO reads.
- `proc_rdata = 0` when `proc_val = 0`, for any write, or during `rst`.

Inputs: each `inN` passes through a 2-flop synchronizer. MMIO reads return the second flop's value.

Cycle counter:
- Increments by 1 every non-reset cycle.
- Wraps from `32'hFFFF_FFFF` to `0`.
- A write loads exactly `proc_wdata`; no +1 is applied on that edge.

Reset (`rst`):
- Clears `out0`–`out2`, `out_strobe`, the counter, and all synchronizer flops to `0`.
- Has priority over a coincident write: the write is dropped and no strobe is raised.
- A reset arriving mid-stream discards nothing pending, because the bridge holds no transaction state.

## Timing
- Memory path is fully combinational, so its latency is whatever Memory presents. The bridge never adds a wait state.
- MMIO read: combinational, returned in the same cycle as `proc_val`.
- MMIO write in cycle t:
  - Register updates at the end of t and is visible on `outN` and to reads from t+1.
  - `out_strobe[N]` is high for cycle t+1 only.
  - Back-to-back writes keep the strobe high on consecutive cycles.
- Input latency: a change on `inN` before edge k is readable after edge k+1 (two edges).
- A counter read in cycle t returns the value held during t. The next cycle reads that value +1, unless a load occurred.

## Structure
- Package `mmio_pkg`:
  - `MMIO_BASE` default.
  - Offset localparams `IN0_OFS` … `CNT_OFS` (0x00–0x1C).
  - Enum `mmio_reg_t` for the decoded register select.
- Sub-module `mmio_sync2`: parameterized-width two-flop synchronizer with synchronous reset, instantiated three times.
- Everything else lives in `mmio_bridge`: decode, output registers, strobes, counter, read mux.

## Test plan
- Reset held for 2 cycles, then released:
  - `out0`–`out2`, `out_strobe`, and `proc_rdata` read `0`.
  - Counter read on the first post-reset cycle returns `0`; the next cycle returns `1`.
- Pass-through: write `0xDEADBEEF` to `0x100`, then read `0x100` -> `mem_val=1`, `mem_addr=0x100`, and `proc_rdata=0xDEADBEEF`. Drive `mem_wait=1` -> `proc_wait=1`.
- Store `0x4` to `0x210` at cycle t:
  - `out0=4` and `out_strobe=3'b001` at t+1.
  - `out_strobe=0` at t+2.
  - `mem_val` stays `0` throughout.
- `in1` changes from `0` to `0x55` before edge k:
  - Read of `0x204` returns `0` after edge k.
  - Read of `0x204` returns `0x55` after edge k+1.
- Write `0xFFFF_FFFE` to `0x21C` -> subsequent reads return `FFFF_FFFE`, `FFFF_FFFF`, `0`.
- Write to `0x200` or `0x220`, and read `0x20C` -> no register or strobe changes, and the read returns `0`. A write to `0x214` coincident with `rst` leaves `out1=0` and raises no strobe.
